// File: rtl/act_pingpong_buffer.sv
// Double-buffered activation store between two NN layers: the producer fills one
// bank (activation applied on write) while the consumer reads the other bank.
module act_pingpong_buffer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = 16,
   parameter int ACT_MODE    = 1,
   parameter int LEAKY_SHIFT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_release,
   output logic              rd_avail,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              addr_err,
   output logic              ovf_err
);
   localparam int              IDX_W     = $clog2(2 * DEPTH);
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   // Both banks share one array: bank 1 occupies words DEPTH..2*DEPTH-1.
   logic [DATA_W-1:0] mem [0:2*DEPTH-1];

   logic              wr_bank_reg, wr_bank_next;
   logic              rd_bank_reg, rd_bank_next;
   logic [1:0]        bank_full_reg, bank_full_next;
   logic              addr_err_reg, addr_err_next;
   logic              ovf_err_reg, ovf_err_next;
   logic              rd_valid_reg;
   logic [DATA_W-1:0] rd_data_reg;

   logic              wr_fire, commit, rel_fire, rd_fire;
   logic              wr_in_range, rd_in_range, wr_store;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_W-1:0] act_data;

   assign wr_ready    = ~bank_full_reg[wr_bank_reg];
   assign rd_avail    = bank_full_reg[rd_bank_reg];
   assign wr_fire     = wr_en & wr_ready;
   assign commit      = wr_fire & wr_last;
   assign rel_fire    = rd_release & rd_avail;
   assign rd_fire     = rd_en & rd_avail;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
   assign wr_store    = wr_fire & wr_in_range;
   assign wr_idx      = wr_bank_reg ? IDX_W'(DEPTH) + IDX_W'(wr_addr) : IDX_W'(wr_addr);
   assign rd_idx      = rd_bank_reg ? IDX_W'(DEPTH) + IDX_W'(rd_addr) : IDX_W'(rd_addr);

   always_comb begin
      act_data = wr_data;
      if (ACT_MODE == 1 && wr_data[DATA_W-1]) begin
         act_data = '0;
      end else if (ACT_MODE == 2 && wr_data[DATA_W-1]) begin
         act_data = $signed(wr_data) >>> LEAKY_SHIFT;
      end
   end

   // Commit and release always hit different banks, so both may apply on one edge.
   always_comb begin
      wr_bank_next   = wr_bank_reg;
      rd_bank_next   = rd_bank_reg;
      bank_full_next = bank_full_reg;
      addr_err_next  = addr_err_reg;
      ovf_err_next   = ovf_err_reg;
      if (commit) begin
         bank_full_next[wr_bank_reg] = 1'b1;
         wr_bank_next                = ~wr_bank_reg;
      end
      if (rel_fire) begin
         bank_full_next[rd_bank_reg] = 1'b0;
         rd_bank_next                = ~rd_bank_reg;
      end
      if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
         addr_err_next = 1'b1;
      end
      if ((wr_en && !wr_ready) || (rd_en && !rd_avail)) begin
         ovf_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank_reg   <= 1'b0;
         rd_bank_reg   <= 1'b0;
         bank_full_reg <= 2'b00;
         addr_err_reg  <= 1'b0;
         ovf_err_reg   <= 1'b0;
      end else begin
         wr_bank_reg   <= wr_bank_next;
         rd_bank_reg   <= rd_bank_next;
         bank_full_reg <= bank_full_next;
         addr_err_reg  <= addr_err_next;
         ovf_err_reg   <= ovf_err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_store) begin
         mem[wr_idx] <= act_data;
      end
   end

   // Out-of-range reads still complete, returning zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_fire;
         if (rd_fire) begin
            rd_data_reg <= rd_in_range ? mem[rd_idx] : '0;
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign addr_err = addr_err_reg;
   assign ovf_err  = ovf_err_reg;
endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Bench for act_pingpong_buffer: a ReLU and a leaky-ReLU instance share stimulus and are
// compared against a layer-queue model of the ping-pong protocol.
module tb_act_pingpong_buffer;
   localparam int DEPTH = 64;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wr_en = 1'b0, wr_last = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
   logic [15:0] wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_ready_r, rd_avail_r, rd_valid_r, addr_err_r, ovf_err_r;
   logic        wr_ready_l, rd_avail_l, rd_valid_l, addr_err_l, ovf_err_l;
   logic [31:0] rd_data_r, rd_data_l;

   act_pingpong_buffer #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16), .ACT_MODE(1), .LEAKY_SHIFT(3)) u_relu (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_last(wr_last), .wr_ready(wr_ready_r), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_release(rd_release), .rd_avail(rd_avail_r), .rd_data(rd_data_r),
      .rd_valid(rd_valid_r), .addr_err(addr_err_r), .ovf_err(ovf_err_r));

   act_pingpong_buffer #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16), .ACT_MODE(2), .LEAKY_SHIFT(3)) u_leaky (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_last(wr_last), .wr_ready(wr_ready_l), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_release(rd_release), .rd_avail(rd_avail_l), .rd_data(rd_data_l),
      .rd_valid(rd_valid_l), .addr_err(addr_err_l), .ovf_err(ovf_err_l));

   always #5 clk = ~clk;

   // Model: committed layers form a FIFO of at most two; layer ids map to slots of a ring.
   int total = 0, bad = 0;
   int cnt, w_id, r_id;
   int exp_r [4][DEPTH];
   int exp_l [4][DEPTH];
   bit known [4][DEPTH];
   int e_rd_r, e_rd_l;
   bit e_known, e_valid, e_aerr, e_oerr;

   function automatic int relu(input int x);
      return (x < 0) ? 0 : x;
   endfunction

   function automatic int leaky(input int x);
      return (x < 0) ? -((-x + 7) / 8) : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
      end
   endtask

   task automatic clear_slot(input int id);
      for (int i = 0; i < DEPTH; i++) known[id % 4][i] = 1'b0;
   endtask

   task automatic check_after_edge();
      chk("rd_valid_r", {31'd0, rd_valid_r}, {31'd0, e_valid});
      chk("rd_valid_l", {31'd0, rd_valid_l}, {31'd0, e_valid});
      if (e_known) begin
         chk("rd_data_r", rd_data_r, e_rd_r);
         chk("rd_data_l", rd_data_l, e_rd_l);
      end
      chk("addr_err_r", {31'd0, addr_err_r}, {31'd0, e_aerr});
      chk("addr_err_l", {31'd0, addr_err_l}, {31'd0, e_aerr});
      chk("ovf_err_r", {31'd0, ovf_err_r}, {31'd0, e_oerr});
      chk("ovf_err_l", {31'd0, ovf_err_l}, {31'd0, e_oerr});
   endtask

   task automatic cycle(input bit we, input int wa, input int wd, input bit wl,
                        input bit re, input int ra, input bit rel);
      bit ready, avail;
      wr_en = we; wr_addr = 16'(wa); wr_data = wd; wr_last = wl;
      rd_en = re; rd_addr = 16'(ra); rd_release = rel;
      ready = (cnt < 2);
      avail = (cnt > 0);
      chk("wr_ready_r", {31'd0, wr_ready_r}, {31'd0, ready});
      chk("wr_ready_l", {31'd0, wr_ready_l}, {31'd0, ready});
      chk("rd_avail_r", {31'd0, rd_avail_r}, {31'd0, avail});
      chk("rd_avail_l", {31'd0, rd_avail_l}, {31'd0, avail});
      e_valid = re && avail;
      if (re && avail) begin
         if (ra < DEPTH) begin
            e_known = known[r_id % 4][ra];
            e_rd_r  = exp_r[r_id % 4][ra];
            e_rd_l  = exp_l[r_id % 4][ra];
         end else begin
            e_known = 1'b1; e_rd_r = 0; e_rd_l = 0;
         end
      end
      if ((we && ready && wa >= DEPTH) || (re && avail && ra >= DEPTH)) e_aerr = 1'b1;
      if ((we && !ready) || (re && !avail)) e_oerr = 1'b1;
      if (we && ready) begin
         if (wa < DEPTH) begin
            exp_r[w_id % 4][wa] = relu(wd);
            exp_l[w_id % 4][wa] = leaky(wd);
            known[w_id % 4][wa] = 1'b1;
         end
         if (wl) begin
            cnt++; w_id++; clear_slot(w_id);
         end
      end
      if (rel && avail) begin
         cnt--; r_id++;
      end
      @(posedge clk);
      #1;
      check_after_edge();
   endtask

   task automatic do_reset();
      wr_en = 0; wr_last = 0; rd_en = 0; rd_release = 0; rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0; r_id = w_id; clear_slot(w_id);
      e_rd_r = 0; e_rd_l = 0; e_known = 1'b1; e_valid = 1'b0; e_aerr = 1'b0; e_oerr = 1'b0;
      check_after_edge();
   endtask

   function automatic int rnd_data();
      int v;
      v = int'($urandom);
      return v >>> 1;
   endfunction

   initial begin
      cnt = 0; w_id = 0; r_id = 0;
      for (int s = 0; s < 4; s++) clear_slot(s);

      // Reset state
      do_reset();

      // Layer 0: data = addr-32, committed on addr 63
      for (int a = 0; a < DEPTH; a++) cycle(1, a, a - 32, a == DEPTH - 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 5, 0);
      chk("t1_rd5_relu", rd_data_r, 32'd0);
      chk("t1_rd5_leaky", rd_data_l, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 1, 40, 0);
      chk("t1_rd40_relu", rd_data_r, 32'd8);
      chk("t1_rd40_leaky", rd_data_l, 32'd8);
      cycle(0, 0, 0, 0, 0, 0, 0);

      // Fill layer 1 while reading layer 0, then release with a same-cycle read
      for (int a = 0; a < DEPTH; a++)
         cycle(1, a, rnd_data(), a == DEPTH - 1, 1, $urandom_range(0, DEPTH - 1), 0);
      chk("t2_full_ready", {31'd0, wr_ready_r}, 32'd0);
      cycle(0, 0, 0, 0, 1, 10, 1);
      chk("t2_ready_back", {31'd0, wr_ready_r}, 32'd1);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, $urandom_range(0, DEPTH - 1), 0);

      // Leaky scaling of -64 and +64
      cycle(1, 0, -64, 0, 0, 0, 0);
      cycle(1, 1, 64, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 0, 0);
      chk("t3_neg_leaky", rd_data_l, 32'hFFFF_FFF8);
      chk("t3_neg_relu", rd_data_r, 32'd0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      chk("t3_pos_leaky", rd_data_l, 32'd64);

      // Commit and release on the same edge with one bank full
      cycle(1, 2, 123, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 2, 0);
      chk("t5_swap_data", rd_data_r, 32'd123);

      // Errors: out-of-range write, then read while empty
      cycle(1, 70, 999, 0, 0, 0, 0);
      chk("t4_addr_err", {31'd0, addr_err_r}, 32'd1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 3, 0);
      chk("t4_ovf_err", {31'd0, ovf_err_r}, 32'd1);
      chk("t4_no_valid", {31'd0, rd_valid_r}, 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic including out-of-range addresses and overflow attempts
      for (int i = 0; i < 800; i++) begin
         int wa, ra;
         wa = ($urandom_range(0, 99) < 5) ? $urandom_range(DEPTH, DEPTH + 6) : $urandom_range(0, DEPTH - 1);
         ra = ($urandom_range(0, 99) < 5) ? $urandom_range(DEPTH, DEPTH + 6) : $urandom_range(0, DEPTH - 1);
         cycle(1'($urandom_range(0, 1)), wa, rnd_data(), $urandom_range(0, 15) == 0,
               1'($urandom_range(0, 1)), ra, $urandom_range(0, 19) == 0);
      end

      // Reset in the middle of a fill, then a normal fill and full readback
      do_reset();
      for (int a = 0; a < 20; a++) cycle(1, a, rnd_data(), 0, 0, 0, 0);
      do_reset();
      for (int a = 0; a < DEPTH; a++) cycle(1, a, rnd_data(), a == DEPTH - 1, 0, 0, 0);
      for (int a = 0; a < DEPTH; a++) cycle(0, 0, 0, 0, 1, a, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
